// File: rtl/reg_bank_rr_arbiter.sv
// Register bank whose single write port is shared round-robin between NREQ requesters.
// Writes land on the sampling edge; gnt/ack/err report the completed write one cycle later.
module reg_bank_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 3,
  parameter int NREG = 8,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   wr_addr,
  input  logic [NREQ*DW-1:0]   wr_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 ack,
  output logic                 err,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic [CW-1:0]        commit_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            any_elig;
  logic [NREQ-1:0] eligible;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            win_in_range;
  logic [DW-1:0]   regs [NREG];
  int              idx;

  // Last cycle's grantee is masked so a held req cannot be granted twice in a row.
  assign eligible = req & ~gnt;

  always_comb begin
    win      = ptr;
    any_elig = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        win_addr = wr_addr[i*AW +: AW];
        win_data = wr_data[i*DW +: DW];
      end
    end
  end

  assign win_in_range = {1'b0, win_addr} < NREG_LIM;
  assign rd_data      = ({1'b0, rd_addr} < NREG_LIM) ? regs[rd_addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      commit_cnt <= '0;
      ptr        <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (any_elig) begin
      gnt <= NREQ'(1) << win;
      ack <= 1'b1;
      err <= !win_in_range;
      ptr <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      if (win_in_range) begin
        regs[win_addr] <= win_data;
        commit_cnt     <= commit_cnt + CW'(1);
      end
    end else begin
      gnt <= '0;
      ack <= 1'b0;
      err <= 1'b0;
    end
  end

endmodule
